// File: rtl/cart_mem_bridge.sv
// cart_mem_bridge
//   Turns Z80-style cartridge memory cycles into single request/acknowledge
//   transactions on a byte-wide memory port. It inserts CPU wait states while
//   a transaction is outstanding and abandons a transaction that the memory
//   controller never acknowledges.
//
//   Optional feature: define CART_READ_CACHE_EN to add a one-entry read cache.
//   A read that hits the cache completes with no memory request and no wait.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   cpu_mreq/rd/wr      CPU memory strobes (active-high, synchronous to clk)
//   cpu_din             CPU write data
//   cs                  slot/subslot select for this cartridge
//   mem_addr            translated address from the upstream mapper
//   mem_unmaped         upstream says the address is unmapped
//   sram_en             upstream says the address is writable SRAM
//   cpu_dout            read data to the CPU
//   cpu_wait            CPU wait request (combinational)
//   ram_req, ram_we     memory request and write qualifier
//   ram_addr, ram_din   memory address and write data
//   ram_dout, ram_ack   memory read data and single-cycle acknowledge
//   timeout_err         sticky: a memory request timed out
module cart_mem_bridge (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_mreq,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_din,
  input  logic        cs,
  input  logic [24:0] mem_addr,
  input  logic        mem_unmaped,
  input  logic        sram_en,
  output logic [7:0]  cpu_dout,
  output logic        cpu_wait,
  output logic        ram_req,
  output logic        ram_we,
  output logic [24:0] ram_addr,
  output logic [7:0]  ram_din,
  input  logic [7:0]  ram_dout,
  input  logic        ram_ack,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, HOLD = 2'd2} state_t;

  state_t      state;
  state_t      state_next;
  logic        qual;
  logic        qual_prev;
  logic        start;
  logic        idle_start;
  logic        unmapped_rd;
  logic        need_mem;
  logic        go;
  logic        done;
  logic        timeout;
  logic        hit;
  logic [7:0]  hit_data;
  logic [7:0]  rd_data;
  logic [7:0]  count;

  // A held strobe is one access: only the rising edge of the qualified strobe starts one.
  assign qual        = cs & cpu_mreq & (cpu_rd | cpu_wr);
  assign start       = qual & ~qual_prev;
  assign idle_start  = start & (state == IDLE);
  // A cycle with both strobes set is treated as a write.
  assign unmapped_rd = ~cpu_wr & mem_unmaped;
  assign done        = (state == REQ) & ram_ack;
  // The count reaches 255 in this cycle; an ack in the same cycle still wins.
  assign timeout     = (state == REQ) & ~ram_ack & (count == 8'd254);
  assign go          = idle_start & need_mem;

  // Decide whether a starting access needs the memory port.
  always_comb begin
    need_mem = 1'b0;
    if (cpu_wr) begin
      need_mem = sram_en & ~mem_unmaped;
    end else begin
      need_mem = ~mem_unmaped & ~hit;
    end
  end

`ifdef CART_READ_CACHE_EN
  logic        cache_valid;
  logic [24:0] cache_tag;
  logic [7:0]  cache_data;

  assign hit      = cache_valid & (cache_tag == mem_addr) & ~cpu_wr & ~mem_unmaped;
  assign hit_data = cache_data;

  // Fill on every completed read; keep the entry coherent with completed writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      cache_valid <= 1'b0;
      cache_tag   <= 25'd0;
      cache_data  <= 8'h00;
    end else if (done & ~ram_we) begin
      cache_valid <= 1'b1;
      cache_tag   <= ram_addr;
      cache_data  <= ram_dout;
    end else if (done & ram_we & cache_valid & (ram_addr == cache_tag)) begin
      cache_data  <= ram_din;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = 8'hFF;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (go) state_next = REQ;
        else    state_next = IDLE;
      end
      REQ: begin
        if (ram_ack | timeout) state_next = HOLD;
        else                   state_next = REQ;
      end
      HOLD: begin
        if (!cpu_mreq) state_next = IDLE;
        else           state_next = HOLD;
      end
      default: state_next = IDLE;
    endcase
  end

  // CPU-facing outputs; unmapped reads and cache hits answer in the start cycle.
  always_comb begin
    cpu_wait = go | (state == REQ);
    cpu_dout = rd_data;
    if (idle_start & unmapped_rd) begin
      cpu_dout = 8'hFF;
    end else if (idle_start & hit) begin
      cpu_dout = hit_data;
    end else begin
      cpu_dout = rd_data;
    end
  end

  // Memory port registers, read-data holding register, timeout counter and flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      qual_prev   <= 1'b0;
      ram_req     <= 1'b0;
      ram_we      <= 1'b0;
      ram_addr    <= 25'd0;
      ram_din     <= 8'h00;
      rd_data     <= 8'hFF;
      count       <= 8'd0;
      timeout_err <= 1'b0;
    end else begin
      qual_prev <= qual;

      if (go) begin
        ram_req  <= 1'b1;
        ram_we   <= cpu_wr;
        ram_addr <= mem_addr;
        ram_din  <= cpu_din;
      end else if (done | timeout) begin
        ram_req  <= 1'b0;
      end

      if (go) begin
        count <= 8'd0;
      end else if (state == REQ) begin
        count <= count + 8'd1;
      end

      if (done & ~ram_we) begin
        rd_data <= ram_dout;
      end else if (timeout) begin
        rd_data <= 8'hFF;
      end else if (idle_start & unmapped_rd) begin
        rd_data <= 8'hFF;
      end else if (idle_start & hit) begin
        rd_data <= hit_data;
      end

      if (timeout) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cart_mem_bridge.sv
module tb_cart_mem_bridge;

  logic        clk;
  logic        reset;
  logic        cpu_mreq;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [7:0]  cpu_din;
  logic        cs;
  logic [24:0] mem_addr;
  logic        mem_unmaped;
  logic        sram_en;
  logic [7:0]  cpu_dout;
  logic        cpu_wait;
  logic        ram_req;
  logic        ram_we;
  logic [24:0] ram_addr;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic        ram_ack;
  logic        timeout_err;

  typedef struct {
    logic [24:0] addr;
    logic        we;
    logic [7:0]  din;
    int          len;
  } ram_exp_t;

  typedef struct {
    logic        chk;
    logic [7:0]  dout;
    int          waits;
  } cpu_exp_t;

  ram_exp_t ram_q[$];
  cpu_exp_t cpu_q[$];

  int          n_vec;
  int          n_fail;
  int          resp_delay;
  logic [7:0]  resp_data;
  logic        inject_ack;

  cart_mem_bridge dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_mreq    (cpu_mreq),
    .cpu_rd      (cpu_rd),
    .cpu_wr      (cpu_wr),
    .cpu_din     (cpu_din),
    .cs          (cs),
    .mem_addr    (mem_addr),
    .mem_unmaped (mem_unmaped),
    .sram_en     (sram_en),
    .cpu_dout    (cpu_dout),
    .cpu_wait    (cpu_wait),
    .ram_req     (ram_req),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_din     (ram_din),
    .ram_dout    (ram_dout),
    .ram_ack     (ram_ack),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ram(input logic [24:0] a, input logic we, input logic [7:0] d, input int len);
    ram_exp_t r;
    r.addr = a; r.we = we; r.din = d; r.len = len;
    ram_q.push_back(r);
  endtask

  task automatic push_cpu(input logic c, input logic [7:0] d, input int waits);
    cpu_exp_t e;
    e.chk = c; e.dout = d; e.waits = waits;
    cpu_q.push_back(e);
  endtask

  // One CPU access: strobes held for 'hold' cycles, then released and idle.
  task automatic op(input logic wr, input logic [24:0] a, input logic [7:0] d,
                    input logic unm, input logic sram, input int hold);
    cs = 1'b1; cpu_mreq = 1'b1; cpu_rd = ~wr; cpu_wr = wr;
    mem_addr = a; cpu_din = d; mem_unmaped = unm; sram_en = sram;
    repeat (hold) step();
    cs = 1'b0; cpu_mreq = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0;
    repeat (8) step();
  endtask

  // Memory controller model: ack in the resp_delay-th cycle of ram_req.
  initial begin : responder
    int req_cyc;
    req_cyc  = 0;
    ram_ack  = 1'b0;
    ram_dout = 8'h00;
    forever begin
      @(posedge clk);
      #2;
      if (ram_req) req_cyc++;
      else         req_cyc = 0;
      if (inject_ack) begin
        ram_ack  = 1'b1;
        ram_dout = 8'h77;
      end else if (ram_req && resp_delay != 0 && req_cyc == resp_delay) begin
        ram_ack  = 1'b1;
        ram_dout = resp_data;
      end else begin
        ram_ack  = 1'b0;
        ram_dout = 8'h00;
      end
    end
  end

  // Monitor: pops expectations when the DUT presents a request or finishes a CPU access.
  initial begin : monitor
    logic     req_prev;
    logic     ram_open;
    logic     qprev;
    logic     q;
    logic     pend;
    int       req_len;
    int       wcnt;
    ram_exp_t re;
    cpu_exp_t ce;
    req_prev = 1'b0; ram_open = 1'b0; qprev = 1'b0; pend = 1'b0;
    req_len = 0; wcnt = 0;
    re.addr = 25'd0; re.we = 1'b0; re.din = 8'h00; re.len = 0;
    ce.chk = 1'b0; ce.dout = 8'h00; ce.waits = 0;
    forever begin
      @(negedge clk);
      if (ram_req && !req_prev) begin
        if (ram_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL ram_req_unexpected: got request at addr %0h, required no request", ram_addr);
          ram_open = 1'b0;
        end else begin
          re = ram_q.pop_front();
          ram_open = 1'b1;
          chk("ram_addr", {7'd0, ram_addr}, {7'd0, re.addr});
          chk("ram_we", {31'd0, ram_we}, {31'd0, re.we});
          chk("ram_din", {24'd0, ram_din}, {24'd0, re.din});
        end
        req_len = 0;
      end
      if (ram_req) req_len++;
      if (!ram_req && req_prev && ram_open) begin
        chk("ram_req_cycles", req_len, re.len);
        ram_open = 1'b0;
      end
      req_prev = ram_req;

      q = cs & cpu_mreq & (cpu_rd | cpu_wr);
      if (q && !qprev && !pend) begin
        if (cpu_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL cpu_access_unexpected: got an access start, required none");
        end else begin
          ce = cpu_q.pop_front();
          pend = 1'b1;
          wcnt = 0;
        end
      end
      qprev = q;
      if (pend) begin
        if (cpu_wait) begin
          wcnt++;
          if (wcnt > 1000) begin
            chk("cpu_wait_bound", wcnt, ce.waits);
            pend = 1'b0;
          end
        end else begin
          chk("cpu_wait_cycles", wcnt, ce.waits);
          if (ce.chk) chk("cpu_dout", {24'd0, cpu_dout}, {24'd0, ce.dout});
          pend = 1'b0;
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ram_req"}, {31'd0, ram_req}, 32'd0);
    chk({tag, "_ram_we"}, {31'd0, ram_we}, 32'd0);
    chk({tag, "_ram_addr"}, {7'd0, ram_addr}, 32'd0);
    chk({tag, "_ram_din"}, {24'd0, ram_din}, 32'd0);
    chk({tag, "_cpu_dout"}, {24'd0, cpu_dout}, 32'h0000_00FF);
    chk({tag, "_cpu_wait"}, {31'd0, cpu_wait}, 32'd0);
    chk({tag, "_timeout_err"}, {31'd0, timeout_err}, 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    n_vec = 0; n_fail = 0;
    reset = 1'b1; cs = 1'b0; cpu_mreq = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0;
    cpu_din = 8'h00; mem_addr = 25'd0; mem_unmaped = 1'b0; sram_en = 1'b0;
    resp_delay = 0; resp_data = 8'h00; inject_ack = 1'b0;

    repeat (3) step();
    @(negedge clk);
    check_reset_outputs("reset");
    step();
    reset = 1'b0;
    step();

    // Mapped read, ack in the 3rd request cycle.
    resp_delay = 3; resp_data = 8'h5A;
    push_ram(25'h0080123, 1'b0, 8'h00, 3);
    push_cpu(1'b1, 8'h5A, 4);
    op(1'b0, 25'h0080123, 8'h00, 1'b0, 1'b0, 6);

    // SRAM write, then the same write without sram_en, then unmapped write.
    resp_delay = 2;
    push_ram(25'h0000010, 1'b1, 8'hC3, 2);
    push_cpu(1'b0, 8'h00, 3);
    op(1'b1, 25'h0000010, 8'hC3, 1'b0, 1'b1, 5);
    push_cpu(1'b0, 8'h00, 0);
    op(1'b1, 25'h0000010, 8'hC3, 1'b0, 1'b0, 4);
    push_cpu(1'b0, 8'h00, 0);
    op(1'b1, 25'h0000010, 8'hC3, 1'b1, 1'b1, 4);

    // Unmapped read.
    push_cpu(1'b1, 8'hFF, 0);
    op(1'b0, 25'h0000321, 8'h00, 1'b1, 1'b0, 3);

    // Two reads of the same address, a write to it, then a read back.
    resp_delay = 1; resp_data = 8'h11;
    push_ram(25'h0004000, 1'b0, 8'h00, 1);
    push_cpu(1'b1, 8'h11, 2);
    op(1'b0, 25'h0004000, 8'h00, 1'b0, 1'b0, 4);
`ifdef CART_READ_CACHE_EN
    push_cpu(1'b1, 8'h11, 0);
`else
    push_ram(25'h0004000, 1'b0, 8'h00, 1);
    push_cpu(1'b1, 8'h11, 2);
`endif
    op(1'b0, 25'h0004000, 8'h00, 1'b0, 1'b0, 4);
    push_ram(25'h0004000, 1'b1, 8'h22, 1);
    push_cpu(1'b0, 8'h00, 2);
    op(1'b1, 25'h0004000, 8'h22, 1'b0, 1'b1, 4);
    resp_data = 8'h22;
`ifdef CART_READ_CACHE_EN
    push_cpu(1'b1, 8'h22, 0);
`else
    push_ram(25'h0004000, 1'b0, 8'h00, 1);
    push_cpu(1'b1, 8'h22, 2);
`endif
    op(1'b0, 25'h0004000, 8'h00, 1'b0, 1'b0, 4);

    // Highest address.
    resp_delay = 2; resp_data = 8'hA5;
    push_ram(25'h1FFFFFF, 1'b0, 8'h00, 2);
    push_cpu(1'b1, 8'hA5, 3);
    op(1'b0, 25'h1FFFFFF, 8'h00, 1'b0, 1'b0, 5);

    // Strobes drop right after the start cycle; the request still completes.
    resp_delay = 4; resp_data = 8'h96;
    push_ram(25'h0000200, 1'b0, 8'h00, 4);
    push_cpu(1'b1, 8'h96, 5);
    op(1'b0, 25'h0000200, 8'h00, 1'b0, 1'b0, 1);

    // No acknowledge: timeout after 255 request cycles, strobe held 300 cycles.
    resp_delay = 0;
    chk("timeout_err_before", {31'd0, timeout_err}, 32'd0);
    push_ram(25'h0000ABC, 1'b0, 8'h00, 255);
    push_cpu(1'b1, 8'hFF, 256);
    op(1'b0, 25'h0000ABC, 8'h00, 1'b0, 1'b0, 300);
    @(negedge clk);
    chk("timeout_err_after", {31'd0, timeout_err}, 32'd1);
    chk("timeout_cpu_dout", {24'd0, cpu_dout}, 32'h0000_00FF);
    step();

    // Reset mid-request, then a stray ack one cycle later.
    push_ram(25'h0000555, 1'b0, 8'h00, 2);
    push_cpu(1'b1, 8'hFF, 3);
    cs = 1'b1; cpu_mreq = 1'b1; cpu_rd = 1'b1; cpu_wr = 1'b0;
    mem_addr = 25'h0000555; mem_unmaped = 1'b0; sram_en = 1'b0;
    step();
    step();
    reset = 1'b1; cs = 1'b0; cpu_mreq = 1'b0; cpu_rd = 1'b0;
    step();
    reset = 1'b0; inject_ack = 1'b1;
    step();
    inject_ack = 1'b0;
    step();
    @(negedge clk);
    check_reset_outputs("abort");
    step();

    // The bridge is idle again and serves a fresh read.
    resp_delay = 2; resp_data = 8'h3C;
    push_ram(25'h0000321, 1'b0, 8'h00, 2);
    push_cpu(1'b1, 8'h3C, 3);
    op(1'b0, 25'h0000321, 8'h00, 1'b0, 1'b0, 5);

    repeat (4) step();
    chk("ram_queue_drained", ram_q.size(), 32'd0);
    chk("cpu_queue_drained", cpu_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
